dispatch_sched: RTL and testbench
=================================

// Module: dispatch_sched
// PURPOSE
//  Issue-stage scheduler between decode and the reservation stations (RS). Per decoded instruction it
//  allocates a ROB entry (circular, tags 1..ROB_DEPTH) and the lowest free slot in the matching RS class
//  (add/sub, mul/div, load). It back-pressures decode when either resource is exhausted.
//  Slot busy bits clear on execute release; ROB entries free on in-order commit.
// PARAMETERS
//  ROB_DEPTH  8  ROB entries; tag width TAG_W = $clog2(ROB_DEPTH+1); tag 0 = "no tag"
//  AS_SLOTS   3  add/sub RS slots
//  MD_SLOTS   2  mul/div RS slots
//  LD_SLOTS   3  load buffer slots
// PORTS
//  clk1         in   1      clock; all state on posedge
//  rst          in   1      synchronous, active-high reset
//  dec_valid    in   1      decode presents an instruction
//  dec_type     in   3      001 LD, 010 ADD, 011 SUB, 100 MUL, 101 DIV; others illegal
//  dec_ready    out  1      scheduler accepts this cycle (combinational from registered state)
//  iss_valid    out  1      registered 1-cycle pulse: allocation result valid
//  iss_rob_tag  out  TAG_W  allocated ROB tag (1..ROB_DEPTH)
//  iss_class    out  2      0 add/sub, 1 mul/div, 2 load
//  iss_slot     out  2      allocated slot index within class
//  as_release   in   AS_SLOTS  per-slot free pulse from add/sub unit
//  md_release   in   MD_SLOTS  per-slot free pulse from mul/div unit
//  ld_release   in   LD_SLOTS  per-slot free pulse from load unit
//  commit_valid in   1      retire ROB head this cycle
//  flush        in   1      discard all in-flight state
//  rob_head     out  TAG_W  tag at ROB head; 0 when empty
//  rob_count    out  TAG_W  occupied ROB entries
//  err          out  1      sticky: illegal dec_type accepted, or commit while empty
// BEHAVIOUR
//  Reset: state INIT; iss_* = 0, rob_head = 0, rob_count = 0, err = 0, all busy bits 0, tail ptr -> tag 1.
//  FSM: INIT -(1 cycle)-> RUN; RUN -flush-> FLUSH -(1 cycle)-> RUN. dec_ready = 0 in INIT/FLUSH.
//  RUN: dec_ready = !flush && rob_count<ROB_DEPTH && (class of dec_type has a free slot).
//  Illegal dec_type: dec_ready = 1 (no ROB full check); handshake consumes it, sets err, no allocation, no iss_valid.
//  Handshake dec_valid&&dec_ready: next cycle iss_valid=1 with tail tag, class, lowest-index free slot;
//   that slot's busy bit sets; tail advances, wrapping ROB_DEPTH -> 1; rob_count +1. Latency 1 cycle.
//  Release pulse on a slot clears busy next cycle. dec_ready uses registered busy only (no bypass):
//   release and a full-class request in the same cycle -> request stalls one cycle.
//  Release on an already-free slot: ignored.
//  Commit: head advances (wrap ROB_DEPTH -> 1), rob_count -1. Commit while empty: ignored, err set.
//  Commit + allocate same cycle: rob_count unchanged. When full, commit does not enable a same-cycle allocate.
//  flush (any state except INIT): next cycle all busy = 0, head = tail = tag 1, rob_count = 0, iss_valid = 0.
//   A same-cycle handshake is suppressed (dec_ready already 0). flush dominates release/commit.
//  rst mid-operation: identical to reset, regardless of FSM state or pending pulses.
// CONFIGURATION
//  DISPATCH_STATS_EN defined: extra outputs stall_cnt[15:0] and issue_cnt[15:0].
//   stall_cnt counts RUN cycles with dec_valid && !dec_ready. issue_cnt counts iss_valid pulses.
//   Both saturate at 16'hFFFF, clear on rst, and are not cleared by flush.
//  Undefined: ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  tomasulo_pkg: in_type encodings (LD/ADD/SUB/MUL/DIV), class enum, FSM state enum, type->class function.
//  Sub-module slot_alloc #(N): busy vector in, lowest-free index + any_free out (combinational).
//   Instantiated once per RS class.
// TESTING
//  After rst: 1 cycle dec_ready=0 (INIT). ADD issued -> iss_valid, tag 1, class 0, slot 0; rob_count=1.
//  4 back-to-back ADD/SUB, no release -> tags 1..3 in slots 0..2; 4th stalls until as_release[1];
//   then issues one cycle later into slot 1 with tag 4.
//  8 LD/MUL mix with releases, no commit -> rob_count=8, dec_ready=0; commit -> next dec_ready=1;
//   allocation wraps to tag 1.
//  flush with 5 in flight and dec_valid high -> no issue; 1 FLUSH cycle; rob_count=0, rob_head=0; next ADD gets tag 1.
//  dec_type=3'b111 accepted -> err=1, no iss_valid. commit_valid on empty ROB -> err stays 1, rob_count stays 0.
//  DISPATCH_STATS_EN: 3 stall cycles then 2 issues -> stall_cnt=3, issue_cnt=2.

Source files
------------

// File: rtl/tomasulo_pkg.sv
// Shared encodings for the issue-stage scheduler: instruction types, RS classes,
// FSM state constants and the type-to-class decode helpers.
package tomasulo_pkg;

    localparam logic [2:0] TYPE_LD  = 3'b001;
    localparam logic [2:0] TYPE_ADD = 3'b010;
    localparam logic [2:0] TYPE_SUB = 3'b011;
    localparam logic [2:0] TYPE_MUL = 3'b100;
    localparam logic [2:0] TYPE_DIV = 3'b101;

    typedef enum logic [1:0] {
        CLS_AS = 2'd0,
        CLS_MD = 2'd1,
        CLS_LD = 2'd2
    } rs_class_t;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;

    function automatic logic type_legal(input logic [2:0] t);
        return (t == TYPE_LD) || (t == TYPE_ADD) || (t == TYPE_SUB) ||
               (t == TYPE_MUL) || (t == TYPE_DIV);
    endfunction

    // Illegal encodings map to add/sub; callers gate on type_legal first.
    function automatic rs_class_t type_to_class(input logic [2:0] t);
        rs_class_t c;
        case (t)
            TYPE_LD:  c = CLS_LD;
            TYPE_MUL,
            TYPE_DIV: c = CLS_MD;
            default:  c = CLS_AS;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/dispatch_sched_slot_alloc.sv
// slot_alloc: combinational lowest-free-slot finder for one reservation-station class.
module slot_alloc #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  busy,
    output logic [IW-1:0] free_idx,
    output logic          any_free
);

    // Scan from the top so the last hit is the lowest free index.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_idx = IW'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dispatch_sched.sv
// Issue-stage scheduler: allocates a ROB tag and the lowest free RS slot per decoded instruction.
// Optional counters stall_cnt/issue_cnt are present when DISPATCH_STATS_EN is defined.
module dispatch_sched
    import tomasulo_pkg::*;
#(
    parameter int ROB_DEPTH = 8,
    parameter int AS_SLOTS  = 3,
    parameter int MD_SLOTS  = 2,
    parameter int LD_SLOTS  = 3,
    parameter int TAG_W     = $clog2(ROB_DEPTH + 1)
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                dec_valid,
    input  logic [2:0]          dec_type,
    output logic                dec_ready,
    output logic                iss_valid,
    output logic [TAG_W-1:0]    iss_rob_tag,
    output logic [1:0]          iss_class,
    output logic [1:0]          iss_slot,
    input  logic [AS_SLOTS-1:0] as_release,
    input  logic [MD_SLOTS-1:0] md_release,
    input  logic [LD_SLOTS-1:0] ld_release,
    input  logic                commit_valid,
    input  logic                flush,
    output logic [TAG_W-1:0]    rob_head,
    output logic [TAG_W-1:0]    rob_count,
    output logic                err
`ifdef DISPATCH_STATS_EN
    ,
    output logic [15:0]         stall_cnt,
    output logic [15:0]         issue_cnt
`endif
);

    localparam logic [TAG_W-1:0] TAG_FIRST = TAG_W'(1);
    localparam logic [TAG_W-1:0] TAG_LAST  = TAG_W'(ROB_DEPTH);

    logic [1:0]          state_reg;
    logic [AS_SLOTS-1:0] as_busy_reg;
    logic [MD_SLOTS-1:0] md_busy_reg;
    logic [LD_SLOTS-1:0] ld_busy_reg;
    logic [TAG_W-1:0]    head_reg, tail_reg, count_reg;
    logic                iss_valid_reg, err_reg;
    logic [TAG_W-1:0]    iss_tag_reg;
    logic [1:0]          iss_class_reg, iss_slot_reg;

    logic [1:0] as_idx, md_idx, ld_idx;
    logic       as_free, md_free, ld_free;

    slot_alloc #(.N(AS_SLOTS), .IW(2)) u_as_alloc (.busy(as_busy_reg), .free_idx(as_idx), .any_free(as_free));
    slot_alloc #(.N(MD_SLOTS), .IW(2)) u_md_alloc (.busy(md_busy_reg), .free_idx(md_idx), .any_free(md_free));
    slot_alloc #(.N(LD_SLOTS), .IW(2)) u_ld_alloc (.busy(ld_busy_reg), .free_idx(ld_idx), .any_free(ld_free));

    rs_class_t     dec_cls;
    logic          dec_legal, cls_free, alloc, commit_ok, flush_now;
    logic [1:0]    alloc_slot;
    logic [AS_SLOTS-1:0] as_set;
    logic [MD_SLOTS-1:0] md_set;
    logic [LD_SLOTS-1:0] ld_set;

    always_comb begin
        dec_cls    = type_to_class(dec_type);
        dec_legal  = type_legal(dec_type);
        cls_free   = 1'b0;
        alloc_slot = 2'd0;
        case (dec_cls)
            CLS_MD:  begin cls_free = md_free; alloc_slot = md_idx; end
            CLS_LD:  begin cls_free = ld_free; alloc_slot = ld_idx; end
            default: begin cls_free = as_free; alloc_slot = as_idx; end
        endcase
        // Illegal types are always drained so decode never wedges on them.
        dec_ready = 1'b0;
        if (state_reg == ST_RUN && !flush)
            dec_ready = dec_legal ? ((count_reg < TAG_LAST) && cls_free) : 1'b1;
        alloc     = dec_valid && dec_ready && dec_legal;
        commit_ok = commit_valid && (count_reg != '0);
        flush_now = flush && (state_reg != ST_INIT);
        as_set    = (alloc && dec_cls == CLS_AS) ? (AS_SLOTS'(1) << as_idx) : '0;
        md_set    = (alloc && dec_cls == CLS_MD) ? (MD_SLOTS'(1) << md_idx) : '0;
        ld_set    = (alloc && dec_cls == CLS_LD) ? (LD_SLOTS'(1) << ld_idx) : '0;
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_reg     <= ST_INIT;
            as_busy_reg   <= '0;
            md_busy_reg   <= '0;
            ld_busy_reg   <= '0;
            head_reg      <= TAG_FIRST;
            tail_reg      <= TAG_FIRST;
            count_reg     <= '0;
            iss_valid_reg <= 1'b0;
            iss_tag_reg   <= '0;
            iss_class_reg <= 2'd0;
            iss_slot_reg  <= 2'd0;
            err_reg       <= 1'b0;
        end else begin
            iss_valid_reg <= 1'b0;
            case (state_reg)
                ST_INIT:  state_reg <= ST_RUN;
                ST_RUN:   state_reg <= flush ? ST_FLUSH : ST_RUN;
                default:  state_reg <= flush ? ST_FLUSH : ST_RUN;
            endcase
            if (dec_valid && dec_ready && !dec_legal)
                err_reg <= 1'b1;
            if (flush_now) begin
                as_busy_reg <= '0;
                md_busy_reg <= '0;
                ld_busy_reg <= '0;
                head_reg    <= TAG_FIRST;
                tail_reg    <= TAG_FIRST;
                count_reg   <= '0;
            end else begin
                as_busy_reg <= (as_busy_reg & ~as_release) | as_set;
                md_busy_reg <= (md_busy_reg & ~md_release) | md_set;
                ld_busy_reg <= (ld_busy_reg & ~ld_release) | ld_set;
                if (alloc) begin
                    iss_valid_reg <= 1'b1;
                    iss_tag_reg   <= tail_reg;
                    iss_class_reg <= dec_cls;
                    iss_slot_reg  <= alloc_slot;
                    tail_reg      <= (tail_reg == TAG_LAST) ? TAG_FIRST : tail_reg + TAG_FIRST;
                end
                if (commit_ok)
                    head_reg <= (head_reg == TAG_LAST) ? TAG_FIRST : head_reg + TAG_FIRST;
                if (commit_valid && !commit_ok)
                    err_reg <= 1'b1;
                if (alloc && !commit_ok)
                    count_reg <= count_reg + TAG_FIRST;
                else if (!alloc && commit_ok)
                    count_reg <= count_reg - TAG_FIRST;
            end
        end
    end

    assign iss_valid   = iss_valid_reg;
    assign iss_rob_tag = iss_tag_reg;
    assign iss_class   = iss_class_reg;
    assign iss_slot    = iss_slot_reg;
    assign rob_count   = count_reg;
    assign rob_head    = (count_reg == '0) ? '0 : head_reg;
    assign err         = err_reg;

`ifdef DISPATCH_STATS_EN
    logic [15:0] stall_cnt_reg, issue_cnt_reg;

    always_ff @(posedge clk1) begin
        if (rst) begin
            stall_cnt_reg <= '0;
            issue_cnt_reg <= '0;
        end else begin
            if (state_reg == ST_RUN && dec_valid && !dec_ready && stall_cnt_reg != 16'hFFFF)
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            if (iss_valid_reg && issue_cnt_reg != 16'hFFFF)
                issue_cnt_reg <= issue_cnt_reg + 16'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign issue_cnt = issue_cnt_reg;
`endif

endmodule

// File: tb/tb_dispatch_sched.sv
// Directed self-checking bench for dispatch_sched: vector tables for plain issues,
// hand sequences for stall/release, ROB wrap, flush, error and (optionally) stats.
module tb_dispatch_sched;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic       dec_valid = 1'b0;
    logic [2:0] dec_type = 3'b000;
    logic       dec_ready;
    logic       iss_valid;
    logic [3:0] iss_rob_tag;
    logic [1:0] iss_class, iss_slot;
    logic [2:0] as_release = '0;
    logic [1:0] md_release = '0;
    logic [2:0] ld_release = '0;
    logic       commit_valid = 1'b0;
    logic       flush = 1'b0;
    logic [3:0] rob_head, rob_count;
    logic       err;
`ifdef DISPATCH_STATS_EN
    logic [15:0] stall_cnt, issue_cnt;
`endif

    dispatch_sched dut (
        .clk1(clk1), .rst(rst),
        .dec_valid(dec_valid), .dec_type(dec_type), .dec_ready(dec_ready),
        .iss_valid(iss_valid), .iss_rob_tag(iss_rob_tag), .iss_class(iss_class), .iss_slot(iss_slot),
        .as_release(as_release), .md_release(md_release), .ld_release(ld_release),
        .commit_valid(commit_valid), .flush(flush),
        .rob_head(rob_head), .rob_count(rob_count), .err(err)
`ifdef DISPATCH_STATS_EN
        , .stall_cnt(stall_cnt), .issue_cnt(issue_cnt)
`endif
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        logic [2:0] t;
        int tag;
        int cls;
        int slot;
        int cnt;
    } vec_t;

    vec_t va[3];
    vec_t vb[4];
    int n_checks = 0;
    int n_pass = 0;

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
        $display("check %-14s got %0d expected %0d", name, act, exp);
    endtask

    task automatic do_issue(input logic [2:0] t, input int tag, input int cls, input int slot, input int cnt);
        int w;
        dec_valid = 1'b1;
        dec_type  = t;
        #1;
        w = 0;
        while (!dec_ready && w < 20) begin
            tick();
            w++;
        end
        if (w >= 20) chk("issue_timeout", w, 0);
        tick();
        dec_valid = 1'b0;
        chk("iss_valid", int'(iss_valid), 1);
        chk("iss_rob_tag", int'(iss_rob_tag), tag);
        chk("iss_class", int'(iss_class), cls);
        chk("iss_slot", int'(iss_slot), slot);
        chk("rob_count", int'(rob_count), cnt);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        va[0] = '{3'b010, 1, 0, 0, 1};
        va[1] = '{3'b011, 2, 0, 1, 2};
        va[2] = '{3'b010, 3, 0, 2, 3};
        vb[0] = '{3'b100, 5, 1, 0, 5};
        vb[1] = '{3'b001, 6, 2, 0, 6};
        vb[2] = '{3'b101, 7, 1, 1, 7};
        vb[3] = '{3'b001, 8, 2, 1, 8};

        // Reset values, then one INIT cycle with dec_ready low.
        tick();
        chk("rst_iss_valid", int'(iss_valid), 0);
        chk("rst_rob_head", int'(rob_head), 0);
        chk("rst_rob_count", int'(rob_count), 0);
        chk("rst_err", int'(err), 0);
        do_reset();
        dec_valid = 1'b1;
        dec_type  = 3'b010;
        #1;
        chk("init_ready", int'(dec_ready), 0);
        tick();
        chk("run_ready", int'(dec_ready), 1);

        for (int i = 0; i < 3; i++) do_issue(va[i].t, va[i].tag, va[i].cls, va[i].slot, va[i].cnt);

        // Add/sub class full: stall, release slot 1, issue one cycle after the release.
        dec_valid = 1'b1;
        dec_type  = 3'b011;
        #1;
        chk("as_full_ready", int'(dec_ready), 0);
        tick();
        chk("stall_no_iss", int'(iss_valid), 0);
        as_release = 3'b010;
        #1;
        chk("rel_same_cyc", int'(dec_ready), 0);
        tick();
        as_release = '0;
        #1;
        chk("rel_next_cyc", int'(dec_ready), 1);
        do_issue(3'b011, 4, 0, 1, 4);

        for (int i = 0; i < 4; i++) do_issue(vb[i].t, vb[i].tag, vb[i].cls, vb[i].slot, vb[i].cnt);

        // ROB full: a free load slot does not help; commit in the same cycle does not either.
        dec_valid = 1'b1;
        dec_type  = 3'b001;
        #1;
        chk("rob_full_ready", int'(dec_ready), 0);
        chk("full_head", int'(rob_head), 1);
        commit_valid = 1'b1;
        #1;
        chk("full_commit_rdy", int'(dec_ready), 0);
        tick();
        commit_valid = 1'b0;
        chk("cmt_count", int'(rob_count), 7);
        chk("cmt_head", int'(rob_head), 2);
        do_issue(3'b001, 1, 2, 2, 8);

        // Retire three with all slots released, then flush while decode presents an ADD.
        as_release = 3'b111;
        md_release = 2'b11;
        ld_release = 3'b111;
        commit_valid = 1'b1;
        tick();
        as_release = '0;
        md_release = '0;
        ld_release = '0;
        tick();
        tick();
        commit_valid = 1'b0;
        chk("pre_flush_cnt", int'(rob_count), 5);
        chk("pre_flush_head", int'(rob_head), 5);
        flush     = 1'b1;
        dec_valid = 1'b1;
        dec_type  = 3'b010;
        #1;
        chk("flush_ready", int'(dec_ready), 0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_iss", int'(iss_valid), 0);
        chk("flush_count", int'(rob_count), 0);
        chk("flush_head", int'(rob_head), 0);
        chk("flush_st_ready", int'(dec_ready), 0);
        tick();
        chk("post_fl_ready", int'(dec_ready), 1);
        do_issue(3'b010, 1, 0, 0, 1);

        // Illegal type: accepted, sets err, no issue, no ROB allocation.
        chk("err_before", int'(err), 0);
        dec_valid = 1'b1;
        dec_type  = 3'b111;
        #1;
        chk("illegal_ready", int'(dec_ready), 1);
        tick();
        dec_valid = 1'b0;
        chk("illegal_iss", int'(iss_valid), 0);
        chk("illegal_err", int'(err), 1);
        chk("illegal_count", int'(rob_count), 1);
        commit_valid = 1'b1;
        tick();
        chk("drain_count", int'(rob_count), 0);
        tick();
        commit_valid = 1'b0;
        chk("empty_cmt_cnt", int'(rob_count), 0);
        chk("empty_cmt_head", int'(rob_head), 0);
        chk("empty_cmt_err", int'(err), 1);

        // Mid-operation reset clears err; commit on empty then sets it on its own.
        do_issue(3'b100, 2, 1, 0, 1);
        do_reset();
        #1;
        chk("rst2_err", int'(err), 0);
        chk("rst2_count", int'(rob_count), 0);
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
        chk("cmt_empty_err", int'(err), 1);
        chk("cmt_empty_cnt", int'(rob_count), 0);

`ifdef DISPATCH_STATS_EN
        do_reset();
        tick();
        do_issue(3'b100, 1, 1, 0, 1);
        do_issue(3'b101, 2, 1, 1, 2);
        dec_valid = 1'b1;
        dec_type  = 3'b101;
        tick();
        tick();
        tick();
        dec_valid = 1'b0;
        tick();
        chk("stall_cnt", int'(stall_cnt), 3);
        chk("issue_cnt", int'(issue_cnt), 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
